mem_region_unit: RTL and testbench
==================================

Name: mem_region_unit

Overview:
- Parametrised, registered successor of the combinational memory controller.
- Holds a run-time-programmable table of NUM_REGIONS address windows, each with base, limit and R/W/X permissions.
- Decodes a data channel and an instruction channel through valid/ready handshakes. Each channel returns device id, local address and exception bits one cycle after acceptance.
- Keeps sticky exception flags and a saturating fault counter for the core's trap logic.

Parameters:
- ADDR_W, 32, address width for both channels and the table.
- NUM_REGIONS, 8, number of table entries (1..15); device id = index+1, 0 = unmapped.
- DEV_W, 4, device id width; must satisfy 2^DEV_W > NUM_REGIONS.
- FAULT_CNT_W, 8, width of the fault counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  table write strobe
- cfg_idx  in  4  entry index to write
- cfg_base  in  ADDR_W  inclusive window start
- cfg_limit  in  ADDR_W  inclusive window end
- cfg_perm  in  4  {enable, R, W, X}
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted when valid&ready
- d_addr  in  ADDR_W  data address
- d_we  in  1  write (1) / read (0)
- d_size  in  2  00 word, 01 half, 10 byte, 11 no access (probe)
- d_rsp_valid  out  1  data response valid
- d_rsp_ready  in  1  consumer takes response
- d_rsp_dev  out  DEV_W  matched device id
- d_rsp_local  out  ADDR_W  local address (addr - base)
- d_rsp_exc  out  2  [0] permission, [1] misaligned
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted
- i_addr  in  ADDR_W  fetch address
- i_rsp_valid  out  1  fetch response valid
- i_rsp_ready  in  1  consumer takes response
- i_rsp_dev  out  DEV_W  matched device id
- i_rsp_local  out  ADDR_W  local address
- i_rsp_exc  out  2  [0] execute fault, [1] misaligned
- exc_sticky  out  4  {i_mis, i_exe, d_mis, d_perm}, set on accepted faulting requests
- exc_clear  in  1  clears exc_sticky
- fault_cnt  out  FAULT_CNT_W  saturating count of accepted faulting transactions

Behaviour:
- Reset (async, rst_n=0): all rsp_valid=0, rsp fields=0, exc_sticky=0, fault_cnt=0.
- Reset table load: entries 0..4 take the package default map; remaining entries are disabled.
  - ROM 0x2000-0x23FF R-X
  - HEX 0x100-0x101 RW-
  - UART 0x200-0x2FF --X
  - VGA 0xEEEE0000-0xEEEEE0FF -W-
  - STACK 0xFFFFF000-0xFFFFFFFF RW-
- Match: entry enabled and base <= addr <= limit (unsigned). Lowest index wins. No match gives dev=0, local=0.
- Data permission fault:
  - d_size=11: never faults.
  - Otherwise faults on a write to a non-W region, or a read from a non-R region.
  - Unmapped data access does not fault.
- Data misaligned: size 00 with addr[1:0]!=0, or size 01 with addr[0]!=0.
- Fetch execute fault: unmapped, or region lacks X. Fetch misaligned: addr[1:0]!=0.
- Handshake per channel: single output register with req_ready = !rsp_valid | rsp_ready. Data and instruction channels are fully independent.
  - Accepted request: response registered next cycle, rsp_valid=1.
  - Response fields hold stable while rsp_valid & !rsp_ready.
  - rsp_valid drops after handshake if no new accept.
  - Back-to-back throughput 1/cycle.
- Config timing: cfg_we writes the entry at the clock edge. A request accepted in the same cycle decodes with the old table. cfg_idx >= NUM_REGIONS is ignored.
- exc_sticky bits are OR-set on acceptance of a faulting request. If exc_clear and a set occur in the same cycle, set wins.
- fault_cnt increments by 1 per channel with a faulting acceptance (+2 if both channels fault in the same cycle) and saturates at all-ones.

Decomposition:
- Package mem_region_pkg holds:
  - perm bit positions
  - size encodings
  - exception bit indices
  - default region table constants (base, limit, perm for 5 entries)
- Sub-module mem_region_decode, instantiated twice (data, instr): combinational table search producing match index, local address and perm bits.

Test Plan:
- Reset, then data read 0x2004 size 00 -> next cycle d_rsp_dev=1, local=0x4, exc=00.
- Data write 0x2000 -> exc[0]=1, exc_sticky[0]=1, fault_cnt=1. Data write size 11 to 0x2000 -> exc=00.
- Data read 0xEEEE0003 size 01 -> dev=4, local=3, exc=11. Fetch 0xFFFFF000 -> i_rsp_dev=5, exc[0]=1. Fetch 0x00000202 -> dev=3, exc[1]=1.
- Hold d_rsp_ready=0 for 3 cycles with new requests -> d_req_ready=0, response fields stable. Release -> next request accepted same cycle, 1/cycle afterwards.
- Program entry 5 at 0x3000-0x3FFF RW- while accepting a read of 0x3010 same cycle -> dev=0. Next read -> dev=6, local=0x10. Overlapping entry 0 wins.
- Force 300 faults -> fault_cnt=255 saturated. Simultaneous exc_clear with a fault -> bit stays set. Assert rst_n mid-response -> rsp_valid=0 immediately.

Source files
------------

// File: rtl/mem_region_pkg.sv
// Shared encodings and the reset-time address map for the memory region unit.
// The default map is exposed through index functions so tables of any depth can load it.
package mem_region_pkg;

    localparam int PERM_EN = 3;
    localparam int PERM_R  = 2;
    localparam int PERM_W  = 1;
    localparam int PERM_X  = 0;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10,
        SIZE_NONE = 2'b11
    } size_e;

    localparam int EXC_PERM = 0;
    localparam int EXC_MIS  = 1;

    localparam int STK_D_PERM = 0;
    localparam int STK_D_MIS  = 1;
    localparam int STK_I_EXE  = 2;
    localparam int STK_I_MIS  = 3;

    localparam int NUM_DEFAULT = 5;

    // Entries past the default map come up with perm=0, i.e. disabled.
    function automatic logic [31:0] def_base(input int idx);
        case (idx)
            0:       def_base = 32'h0000_2000;
            1:       def_base = 32'h0000_0100;
            2:       def_base = 32'h0000_0200;
            3:       def_base = 32'hEEEE_0000;
            4:       def_base = 32'hFFFF_F000;
            default: def_base = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] def_limit(input int idx);
        case (idx)
            0:       def_limit = 32'h0000_23FF;
            1:       def_limit = 32'h0000_0101;
            2:       def_limit = 32'h0000_02FF;
            3:       def_limit = 32'hEEEE_E0FF;
            4:       def_limit = 32'hFFFF_FFFF;
            default: def_limit = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [3:0] def_perm(input int idx);
        case (idx)
            0:       def_perm = 4'b1101;
            1:       def_perm = 4'b1110;
            2:       def_perm = 4'b1001;
            3:       def_perm = 4'b1010;
            4:       def_perm = 4'b1110;
            default: def_perm = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational region search: lowest enabled matching entry wins; no match gives zeros.
// Zero latency, no flow control of its own.
module mem_region_decode
    import mem_region_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int NUM_REGIONS = 8,
    parameter int DEV_W       = 4
) (
    input  logic [ADDR_W-1:0]                   addr,
    input  logic [NUM_REGIONS-1:0][ADDR_W-1:0]  base,
    input  logic [NUM_REGIONS-1:0][ADDR_W-1:0]  limit,
    input  logic [NUM_REGIONS-1:0][3:0]         perm,
    output logic                                hit,
    output logic [DEV_W-1:0]                    dev,
    output logic [ADDR_W-1:0]                   local_addr,
    output logic [3:0]                          hit_perm
);

    // Walk from the top so that a lower-index match overwrites a higher one.
    always_comb begin
        hit        = 1'b0;
        dev        = '0;
        local_addr = '0;
        hit_perm   = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (perm[i][PERM_EN] && (addr >= base[i]) && (addr <= limit[i])) begin
                hit        = 1'b1;
                dev        = DEV_W'(i + 1);
                local_addr = addr - base[i];
                hit_perm   = perm[i];
            end
        end
    end

endmodule

// File: rtl/mem_region_unit.sv
// Programmable region table decoding a data and a fetch channel, one registered response each.
// One cycle accept-to-response; a channel stalls only while its response is held by the consumer.
module mem_region_unit
    import mem_region_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int NUM_REGIONS = 8,
    parameter int DEV_W       = 4,
    parameter int FAULT_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_idx,
    input  logic [ADDR_W-1:0]      cfg_base,
    input  logic [ADDR_W-1:0]      cfg_limit,
    input  logic [3:0]             cfg_perm,
    input  logic                   d_req_valid,
    output logic                   d_req_ready,
    input  logic [ADDR_W-1:0]      d_addr,
    input  logic                   d_we,
    input  logic [1:0]             d_size,
    output logic                   d_rsp_valid,
    input  logic                   d_rsp_ready,
    output logic [DEV_W-1:0]       d_rsp_dev,
    output logic [ADDR_W-1:0]      d_rsp_local,
    output logic [1:0]             d_rsp_exc,
    input  logic                   i_req_valid,
    output logic                   i_req_ready,
    input  logic [ADDR_W-1:0]      i_addr,
    output logic                   i_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [DEV_W-1:0]       i_rsp_dev,
    output logic [ADDR_W-1:0]      i_rsp_local,
    output logic [1:0]             i_rsp_exc,
    output logic [3:0]             exc_sticky,
    input  logic                   exc_clear,
    output logic [FAULT_CNT_W-1:0] fault_cnt
);

    localparam int CW = FAULT_CNT_W + 1;

    logic [NUM_REGIONS-1:0][ADDR_W-1:0] tbl_base;
    logic [NUM_REGIONS-1:0][ADDR_W-1:0] tbl_limit;
    logic [NUM_REGIONS-1:0][3:0]        tbl_perm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                tbl_base[i]  <= ADDR_W'(def_base(i));
                tbl_limit[i] <= ADDR_W'(def_limit(i));
                tbl_perm[i]  <= def_perm(i);
            end
        end else begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (cfg_we && (cfg_idx == 4'(i))) begin
                    tbl_base[i]  <= cfg_base;
                    tbl_limit[i] <= cfg_limit;
                    tbl_perm[i]  <= cfg_perm;
                end
            end
        end
    end

    logic              d_hit, i_hit;
    logic [DEV_W-1:0]  d_dev, i_dev;
    logic [ADDR_W-1:0] d_local, i_local;
    logic [3:0]        d_perm, i_perm;

    mem_region_decode #(.ADDR_W(ADDR_W), .NUM_REGIONS(NUM_REGIONS), .DEV_W(DEV_W)) u_dec_d (
        .addr       (d_addr),
        .base       (tbl_base),
        .limit      (tbl_limit),
        .perm       (tbl_perm),
        .hit        (d_hit),
        .dev        (d_dev),
        .local_addr (d_local),
        .hit_perm   (d_perm)
    );

    mem_region_decode #(.ADDR_W(ADDR_W), .NUM_REGIONS(NUM_REGIONS), .DEV_W(DEV_W)) u_dec_i (
        .addr       (i_addr),
        .base       (tbl_base),
        .limit      (tbl_limit),
        .perm       (tbl_perm),
        .hit        (i_hit),
        .dev        (i_dev),
        .local_addr (i_local),
        .hit_perm   (i_perm)
    );

    // Each channel only consults the permission bits relevant to it.
    logic [4:0] perm_unused;
    assign perm_unused = {d_perm[PERM_EN], d_perm[PERM_X], i_perm[PERM_EN], i_perm[PERM_R], i_perm[PERM_W]};

    logic       d_fire, i_fire;
    logic       d_perm_fault, d_mis, i_exe_fault, i_mis;
    logic [1:0] d_exc, i_exc;

    assign d_req_ready = !d_rsp_valid || d_rsp_ready;
    assign i_req_ready = !i_rsp_valid || i_rsp_ready;
    assign d_fire      = d_req_valid && d_req_ready;
    assign i_fire      = i_req_valid && i_req_ready;

    assign d_perm_fault = (d_size != SIZE_NONE) && d_hit &&
                          (d_we ? !d_perm[PERM_W] : !d_perm[PERM_R]);
    assign d_mis        = ((d_size == SIZE_WORD) && (d_addr[1:0] != 2'b00)) ||
                          ((d_size == SIZE_HALF) && d_addr[0]);
    assign i_exe_fault  = !i_hit || !i_perm[PERM_X];
    assign i_mis        = (i_addr[1:0] != 2'b00);

    always_comb begin
        d_exc           = '0;
        d_exc[EXC_PERM] = d_perm_fault;
        d_exc[EXC_MIS]  = d_mis;
        i_exc           = '0;
        i_exc[EXC_PERM] = i_exe_fault;
        i_exc[EXC_MIS]  = i_mis;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rsp_valid <= 1'b0;
            d_rsp_dev   <= '0;
            d_rsp_local <= '0;
            d_rsp_exc   <= '0;
        end else if (d_fire) begin
            d_rsp_valid <= 1'b1;
            d_rsp_dev   <= d_dev;
            d_rsp_local <= d_local;
            d_rsp_exc   <= d_exc;
        end else if (d_rsp_ready) begin
            d_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rsp_valid <= 1'b0;
            i_rsp_dev   <= '0;
            i_rsp_local <= '0;
            i_rsp_exc   <= '0;
        end else if (i_fire) begin
            i_rsp_valid <= 1'b1;
            i_rsp_dev   <= i_dev;
            i_rsp_local <= i_local;
            i_rsp_exc   <= i_exc;
        end else if (i_rsp_ready) begin
            i_rsp_valid <= 1'b0;
        end
    end

    logic [3:0]    sticky_set;
    logic          d_fault, i_fault;
    logic [CW-1:0] cnt_sum;

    always_comb begin
        sticky_set             = '0;
        sticky_set[STK_D_PERM] = d_fire && d_perm_fault;
        sticky_set[STK_D_MIS]  = d_fire && d_mis;
        sticky_set[STK_I_EXE]  = i_fire && i_exe_fault;
        sticky_set[STK_I_MIS]  = i_fire && i_mis;
    end

    assign d_fault = d_fire && (d_perm_fault || d_mis);
    assign i_fault = i_fire && (i_exe_fault || i_mis);
    assign cnt_sum = {1'b0, fault_cnt} + CW'(d_fault) + CW'(i_fault);

    // Clear is applied before the OR so a same-cycle fault still lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_sticky <= '0;
            fault_cnt  <= '0;
        end else begin
            exc_sticky <= (exc_clear ? 4'b0000 : exc_sticky) | sticky_set;
            fault_cnt  <= cnt_sum[FAULT_CNT_W] ? {FAULT_CNT_W{1'b1}} : cnt_sum[FAULT_CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_mem_region_unit.sv
// Directed-vector bench for mem_region_unit with hand-computed expectations.
module tb_mem_region_unit;
    import mem_region_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [31:0] cfg_base, cfg_limit;
    logic [3:0]  cfg_perm;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_ready;
    logic [31:0] d_addr, d_rsp_local;
    logic [1:0]  d_size, d_rsp_exc;
    logic [3:0]  d_rsp_dev;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
    logic [31:0] i_addr, i_rsp_local;
    logic [3:0]  i_rsp_dev;
    logic [1:0]  i_rsp_exc;
    logic [3:0]  exc_sticky;
    logic        exc_clear;
    logic [7:0]  fault_cnt;

    int n_vec = 0;
    int n_bad = 0;

    mem_region_unit #(.ADDR_W(32), .NUM_REGIONS(8), .DEV_W(4), .FAULT_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_perm(cfg_perm),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr), .d_we(d_we), .d_size(d_size),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_dev(d_rsp_dev),
        .d_rsp_local(d_rsp_local), .d_rsp_exc(d_rsp_exc),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_dev(i_rsp_dev),
        .i_rsp_local(i_rsp_local), .i_rsp_exc(i_rsp_exc),
        .exc_sticky(exc_sticky), .exc_clear(exc_clear), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic d_send(input logic [31:0] a, input logic we, input logic [1:0] sz);
        d_req_valid = 1'b1;
        d_addr      = a;
        d_we        = we;
        d_size      = sz;
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
    endtask

    task automatic i_send(input logic [31:0] a);
        i_req_valid = 1'b1;
        i_addr      = a;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic d_expect(input string tag, input logic [3:0] dev, input logic [31:0] loc, input logic [1:0] exc);
        chk({tag, ".vld"}, 64'(d_rsp_valid), 64'(1'b1));
        chk({tag, ".dev"}, 64'(d_rsp_dev), 64'(dev));
        chk({tag, ".loc"}, 64'(d_rsp_local), 64'(loc));
        chk({tag, ".exc"}, 64'(d_rsp_exc), 64'(exc));
    endtask

    task automatic i_expect(input string tag, input logic [3:0] dev, input logic [31:0] loc, input logic [1:0] exc);
        chk({tag, ".vld"}, 64'(i_rsp_valid), 64'(1'b1));
        chk({tag, ".dev"}, 64'(i_rsp_dev), 64'(dev));
        chk({tag, ".loc"}, 64'(i_rsp_local), 64'(loc));
        chk({tag, ".exc"}, 64'(i_rsp_exc), 64'(exc));
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [31:0] b, input logic [31:0] l, input logic [3:0] p);
        cfg_we = 1'b1; cfg_idx = idx; cfg_base = b; cfg_limit = l; cfg_perm = p;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_limit = '0; cfg_perm = '0;
        d_req_valid = 1'b0; d_addr = '0; d_we = 1'b0; d_size = SIZE_WORD; d_rsp_ready = 1'b1;
        i_req_valid = 1'b0; i_addr = '0; i_rsp_ready = 1'b1; exc_clear = 1'b0;

        #3;
        chk("rst.d_vld", 64'(d_rsp_valid), 64'(0));
        chk("rst.i_vld", 64'(i_rsp_valid), 64'(0));
        chk("rst.d_dev", 64'(d_rsp_dev), 64'(0));
        chk("rst.i_loc", 64'(i_rsp_local), 64'(0));
        chk("rst.sticky", 64'(exc_sticky), 64'(0));
        chk("rst.cnt", 64'(fault_cnt), 64'(0));
        #18 rst_n = 1'b1;
        @(posedge clk); #1;

        // Default map decode across both channels.
        d_send(32'h2004, 1'b0, SIZE_WORD);       d_expect("rom_rd", 4'd1, 32'h4, 2'b00);
        d_send(32'h2000, 1'b1, SIZE_WORD);       d_expect("rom_wr", 4'd1, 32'h0, 2'b01);
        chk("rom_wr.sticky", 64'(exc_sticky), 64'(4'b0001));
        chk("rom_wr.cnt", 64'(fault_cnt), 64'(1));
        d_send(32'h2000, 1'b1, SIZE_NONE);       d_expect("rom_probe", 4'd1, 32'h0, 2'b00);
        chk("rom_probe.cnt", 64'(fault_cnt), 64'(1));
        d_send(32'hEEEE_0003, 1'b0, SIZE_HALF);  d_expect("vga_rd", 4'd4, 32'h3, 2'b11);
        chk("vga_rd.sticky", 64'(exc_sticky), 64'(4'b0011));
        i_send(32'hFFFF_F000);                   i_expect("stk_fetch", 4'd5, 32'h0, 2'b01);
        chk("stk_fetch.sticky", 64'(exc_sticky), 64'(4'b0111));
        i_send(32'h0000_0202);                   i_expect("uart_fetch", 4'd3, 32'h2, 2'b10);
        chk("uart_fetch.sticky", 64'(exc_sticky), 64'(4'b1111));
        chk("uart_fetch.cnt", 64'(fault_cnt), 64'(4));
        d_send(32'h5000, 1'b1, SIZE_WORD);       d_expect("unmap_wr", 4'd0, 32'h0, 2'b00);
        d_send(32'h0101, 1'b0, SIZE_BYTE);       d_expect("hex_lim", 4'd2, 32'h1, 2'b00);
        d_send(32'h0102, 1'b0, SIZE_BYTE);       d_expect("hex_past", 4'd0, 32'h0, 2'b00);
        i_send(32'h5000);                        i_expect("unmap_fetch", 4'd0, 32'h0, 2'b01);
        chk("unmap_fetch.cnt", 64'(fault_cnt), 64'(5));

        exc_clear = 1'b1; @(posedge clk); #1; exc_clear = 1'b0;
        chk("clear.sticky", 64'(exc_sticky), 64'(0));
        chk("idle.d_vld", 64'(d_rsp_valid), 64'(0));

        // Backpressure: held response stays stable, then 1/cycle after release.
        d_rsp_ready = 1'b0;
        d_send(32'h2008, 1'b0, SIZE_WORD);       d_expect("bp_first", 4'd1, 32'h8, 2'b00);
        d_req_valid = 1'b1; d_addr = 32'h2100; d_we = 1'b0; d_size = SIZE_WORD;
        for (int k = 0; k < 3; k++) begin
            chk("bp.req_rdy", 64'(d_req_ready), 64'(0));
            @(posedge clk); #1;
            d_expect("bp_hold", 4'd1, 32'h8, 2'b00);
        end
        d_rsp_ready = 1'b1; #1;
        chk("bp.release_rdy", 64'(d_req_ready), 64'(1));
        @(posedge clk); #1;                      d_expect("tp0", 4'd1, 32'h100, 2'b00);
        d_addr = 32'h2104; @(posedge clk); #1;   d_expect("tp1", 4'd1, 32'h104, 2'b00);
        d_addr = 32'h2108; @(posedge clk); #1;   d_expect("tp2", 4'd1, 32'h108, 2'b00);
        d_req_valid = 1'b0;

        // Table programming: same-edge request sees the old table.
        cfg_we = 1'b1; cfg_idx = 4'd5; cfg_base = 32'h3000; cfg_limit = 32'h3FFF; cfg_perm = 4'b1110;
        d_send(32'h3010, 1'b0, SIZE_WORD);       cfg_we = 1'b0;
        d_expect("cfg_same", 4'd0, 32'h0, 2'b00);
        d_send(32'h3010, 1'b0, SIZE_WORD);       d_expect("cfg_new", 4'd6, 32'h10, 2'b00);
        d_send(32'h3010, 1'b1, SIZE_WORD);       d_expect("cfg_new_wr", 4'd6, 32'h10, 2'b00);
        cfg_write(4'd6, 32'h2000, 32'h2FFF, 4'b1111);
        d_send(32'h2010, 1'b0, SIZE_WORD);       d_expect("overlap", 4'd1, 32'h10, 2'b00);
        d_send(32'h2800, 1'b1, SIZE_WORD);       d_expect("overlap_hi", 4'd7, 32'h800, 2'b00);
        cfg_write(4'd8, 32'h5000, 32'h5FFF, 4'b1111);
        d_send(32'h5000, 1'b0, SIZE_WORD);       d_expect("idx_oob", 4'd0, 32'h0, 2'b00);
        d_send(32'h2004, 1'b0, SIZE_WORD);       d_expect("idx_oob_e0", 4'd1, 32'h4, 2'b00);
        chk("cfg.cnt", 64'(fault_cnt), 64'(5));

        // Fault counter: dual-channel +2, then saturation.
        d_req_valid = 1'b1; d_addr = 32'h2000; d_we = 1'b1; d_size = SIZE_WORD;
        i_req_valid = 1'b1; i_addr = 32'h5000;
        @(posedge clk); #1;
        chk("dual.cnt", 64'(fault_cnt), 64'(7));
        i_req_valid = 1'b0;
        repeat (246) @(posedge clk);
        #1;
        chk("run.cnt", 64'(fault_cnt), 64'(253));
        i_req_valid = 1'b1;
        @(posedge clk); #1;
        chk("sat2.cnt", 64'(fault_cnt), 64'(255));
        @(posedge clk); #1;
        chk("sat_ovf.cnt", 64'(fault_cnt), 64'(255));
        i_req_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        chk("sat.cnt", 64'(fault_cnt), 64'(255));
        chk("sat.sticky", 64'(exc_sticky), 64'(4'b0101));

        // Clear and set in the same cycle: set wins.
        exc_clear = 1'b1;
        d_send(32'h2002, 1'b0, SIZE_WORD);       exc_clear = 1'b0;
        d_expect("clr_set", 4'd1, 32'h2, 2'b10);
        chk("clr_set.sticky", 64'(exc_sticky), 64'(4'b0010));

        // Asynchronous reset while a response is held.
        d_send(32'h2004, 1'b0, SIZE_WORD);
        d_rsp_ready = 1'b0;
        chk("pre_rst.vld", 64'(d_rsp_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.vld", 64'(d_rsp_valid), 64'(0));
        chk("async_rst.dev", 64'(d_rsp_dev), 64'(0));
        chk("async_rst.cnt", 64'(fault_cnt), 64'(0));
        chk("async_rst.sticky", 64'(exc_sticky), 64'(0));
        d_rsp_ready = 1'b1;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        d_send(32'h3010, 1'b0, SIZE_WORD);       d_expect("rst_tbl5", 4'd0, 32'h0, 2'b00);
        d_send(32'h2800, 1'b0, SIZE_WORD);       d_expect("rst_tbl6", 4'd0, 32'h0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
